calc_sequencer: RTL and testbench

- Parametrised operand-entry and execution sequencer for the calculator datapath. Generalises the fixed 18-bit, four-state entry FSM.
- Synchronises the active-low entry keys and steps through operand A, operator, operand B, execute and result.
- Drives a start/done handshake to a multi-cycle arithmetic unit, with a watchdog timeout, error reporting and an optional chain mode (previous result becomes the next A).
- Sits between the board switches/keys and the calculator core; its result feeds the BCD/7-segment path.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_sequencer_key_sync_edge.sv | 29 ++
 rtl/calc_sequencer.sv | 179 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry sequencer.
// Holds the state encoding, error codes and operator codes.
package calc_pkg;

   typedef enum logic [2:0] {
      S_A      = 3'd0,
      S_OP     = 3'd1,
      S_B      = 3'd2,
      S_EXEC   = 3'd3,
      S_RESULT = 3'd4,
      S_ERR    = 3'd5
   } calc_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ALU     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_CHAIN   = 2'b11;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_MUL = 2;
   localparam int OP_DIV = 3;

endpackage

// File: rtl/calc_sequencer_key_sync_edge.sv
// Two-flop synchroniser and falling-edge pulse for an active-low key.
// Ports: i_clk, i_rst (async high), i_key_n (raw pin), o_press (1 cycle).
module key_sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press
);

   logic r_s1;
   logic r_s2;
   logic r_prev;

   // All flops reset to 1 so a released key never looks like a press.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1   <= 1'b1;
         r_s2   <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_s1   <= i_key_n;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign o_press = r_prev & ~r_s2;

endmodule

// File: rtl/calc_sequencer.sv
// Operand entry and execution sequencer with ALU start/done handshake.
// Ports: switches/keys in, op_a/op_b/op_sel/alu_start to ALU, result/status out.
import calc_pkg::*;

module calc_sequencer #(
   parameter int WIDTH     = 18,
   parameter int RES_WIDTH = 27,
   parameter int OP_W      = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic [WIDTH-1:0]     sw_a,
   input  logic [WIDTH-1:0]     sw_b,
   input  logic [OP_W-1:0]      sw_op,
   input  logic                 key_a_n,
   input  logic                 key_op_n,
   input  logic                 key_b_n,
   input  logic                 chain_en,
   output logic [WIDTH-1:0]     op_a,
   output logic [WIDTH-1:0]     op_b,
   output logic [OP_W-1:0]      op_sel,
   output logic                 alu_start,
   input  logic                 alu_done,
   input  logic [RES_WIDTH-1:0] alu_result,
   input  logic                 alu_err,
   output logic [RES_WIDTH-1:0] result,
   output logic                 result_valid,
   output logic                 busy,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [2:0]           state_o
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   calc_state_t          r_state;
   calc_state_t          w_next;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_op_a;
   logic [WIDTH-1:0]     r_op_b;
   logic [OP_W-1:0]      r_op_sel;
   logic [RES_WIDTH-1:0] r_result;
   logic [1:0]           r_err_code;
   logic [1:0]           w_err_code;
   logic                 w_pa;
   logic                 w_po;
   logic                 w_pb;
   logic                 w_fit;
   logic [RES_WIDTH-WIDTH:0] w_hi;

   key_sync_edge u_key_a (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_key_n (key_a_n),
      .o_press (w_pa)
   );

   key_sync_edge u_key_op (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_key_n (key_op_n),
      .o_press (w_po)
   );

   key_sync_edge u_key_b (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_key_n (key_b_n),
      .o_press (w_pb)
   );

   // Result fits signed WIDTH when all bits above the sign bit match it.
   assign w_hi  = r_result[RES_WIDTH-1:WIDTH-1];
   assign w_fit = (&w_hi) | ~(|w_hi);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_A;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_err_code = r_err_code;
      if (clr) begin
         w_next = S_A;
      end else begin
         unique case (r_state)
            S_A:      if (w_pa) w_next = S_OP;
            S_OP:     if (w_po) w_next = S_B;
            S_B:      if (w_pb) w_next = S_EXEC;
            S_EXEC: begin
               // A done in the final counted cycle beats the timeout.
               if (alu_done) begin
                  w_next = alu_err ? S_ERR : S_RESULT;
               end else if (r_cnt == CNT_MAX) begin
                  w_next = S_ERR;
               end
            end
            S_RESULT: begin
               if (w_pa) begin
                  w_next = S_A;
               end else if (w_po && chain_en) begin
                  w_next = w_fit ? S_OP : S_ERR;
               end
            end
            S_ERR:    if (w_pa) w_next = S_A;
            default:  w_next = S_A;
         endcase
      end
      // The code is only non-zero while in S_ERR; latch the cause on entry.
      if (w_next != S_ERR) begin
         w_err_code = ERR_NONE;
      end else if (r_state != S_ERR) begin
         if (r_state == S_EXEC) begin
            w_err_code = alu_done ? ERR_ALU : ERR_TIMEOUT;
         end else begin
            w_err_code = ERR_CHAIN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_sel   <= '0;
         r_result   <= '0;
         r_err_code <= ERR_NONE;
      end else begin
         if (r_state == S_EXEC) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
         if (r_state == S_A) begin
            r_op_a <= sw_a;
         end else if (r_state == S_RESULT && w_next == S_OP) begin
            r_op_a <= r_result[WIDTH-1:0];
         end
         if (r_state == S_OP) r_op_sel <= sw_op;
         if (r_state == S_B)  r_op_b   <= sw_b;
         if (r_state == S_EXEC && w_next == S_RESULT) begin
            r_result <= alu_result;
         end
         r_err_code <= w_err_code;
      end
   end

   always_comb begin
      alu_start    = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      err          = 1'b0;
      unique case (r_state)
         S_EXEC: begin
            busy      = 1'b1;
            alu_start = (r_cnt == '0);
         end
         S_RESULT: result_valid = 1'b1;
         S_ERR:    err          = 1'b1;
         default:  ;
      endcase
   end

   assign op_a     = r_op_a;
   assign op_b     = r_op_b;
   assign op_sel   = r_op_sel;
   assign result   = r_result;
   assign err_code = r_err_code;
   assign state_o  = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a transaction-level reference.
// Drives keys/ALU after each rising edge, checks outputs on falling edges.
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int W  = 18;
   localparam int RW = 27;
   localparam int OW = 2;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic [W-1:0]  sw_a = '0;
   logic [W-1:0]  sw_b = '0;
   logic [OW-1:0] sw_op = '0;
   logic          key_a_n = 1'b1;
   logic          key_op_n = 1'b1;
   logic          key_b_n = 1'b1;
   logic          chain_en = 1'b0;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [OW-1:0] op_sel;
   logic          alu_start;
   logic          alu_done = 1'b0;
   logic [RW-1:0] alu_result = '0;
   logic          alu_err = 1'b0;
   logic [RW-1:0] result;
   logic          result_valid;
   logic          busy;
   logic          err;
   logic [1:0]    err_code;
   logic [2:0]    state_o;

   int n_chk = 0;
   int n_fail = 0;
   int n_start = 0;

   calc_sequencer #(
      .WIDTH(W), .RES_WIDTH(RW), .OP_W(OW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op),
      .key_a_n(key_a_n), .key_op_n(key_op_n), .key_b_n(key_b_n),
      .chain_en(chain_en),
      .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
      .alu_start(alu_start), .alu_done(alu_done),
      .alu_result(alu_result), .alu_err(alu_err),
      .result(result), .result_valid(result_valid),
      .busy(busy), .err(err), .err_code(err_code),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   // Reference: each key acts three edges after its pin is first seen low.
   int                   m_st = 0;
   int                   m_cnt = 0;
   logic [W-1:0]         m_a = '0;
   logic [W-1:0]         m_b = '0;
   logic [OW-1:0]        m_op = '0;
   logic signed [RW-1:0] m_res = '0;
   logic [1:0]           m_code = 2'b00;
   logic [2:0]           ha = 3'b111;
   logic [2:0]           ho = 3'b111;
   logic [2:0]           hb = 3'b111;
   logic                 pa, po, pb;
   int                   rv;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = 0; m_cnt = 0; m_a = '0; m_b = '0; m_op = '0;
         m_res = '0; m_code = 2'b00;
         ha = 3'b111; ho = 3'b111; hb = 3'b111;
      end else begin
         pa = ha[2] & ~ha[1];
         po = ho[2] & ~ho[1];
         pb = hb[2] & ~hb[1];
         case (m_st)
            0: m_a = sw_a;
            1: m_op = sw_op;
            2: m_b = sw_b;
            default: ;
         endcase
         if (clr) begin
            m_st = 0;
            m_code = 2'b00;
         end else begin
            case (m_st)
               0: if (pa) m_st = 1;
               1: if (po) m_st = 2;
               2: if (pb) begin m_st = 3; m_cnt = 0; end
               3: begin
                  if (alu_done) begin
                     if (alu_err) begin
                        m_st = 5; m_code = 2'b01;
                     end else begin
                        m_res = alu_result; m_st = 4;
                     end
                  end else if (m_cnt == TO - 1) begin
                     m_st = 5; m_code = 2'b10;
                  end else begin
                     m_cnt++;
                  end
               end
               4: begin
                  if (pa) begin
                     m_st = 0;
                  end else if (po && chain_en) begin
                     rv = m_res;
                     if (rv >= -(1 << (W - 1)) && rv < (1 << (W - 1))) begin
                        m_a = m_res[W-1:0]; m_st = 1;
                     end else begin
                        m_st = 5; m_code = 2'b11;
                     end
                  end
               end
               5: if (pa) begin m_st = 0; m_code = 2'b00; end
               default: m_st = 0;
            endcase
         end
         ha = {ha[1:0], key_a_n};
         ho = {ho[1:0], key_op_n};
         hb = {hb[1:0], key_b_n};
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         n_start += int'(alu_start);
         chk("state", 32'(state_o), 32'(m_st));
         chk("op_a", 32'(op_a), 32'(m_a));
         chk("op_b", 32'(op_b), 32'(m_b));
         chk("op_sel", 32'(op_sel), 32'(m_op));
         chk("alu_start", 32'(alu_start), 32'(m_st == 3 && m_cnt == 0));
         chk("result", {5'b0, result}, {5'b0, m_res});
         chk("valid", 32'(result_valid), 32'(m_st == 4));
         chk("busy", 32'(busy), 32'(m_st == 3));
         chk("err", 32'(err), 32'(m_st == 5));
         chk("err_code", 32'(err_code), 32'(m_code));
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_key(int k, logic v);
      case (k)
         0: key_a_n = v;
         1: key_op_n = v;
         default: key_b_n = v;
      endcase
   endtask

   task automatic press(int k, int hold);
      set_key(k, 1'b0);
      tick(hold);
      set_key(k, 1'b1);
      tick(4);
   endtask

   // Waits for the start pulse; d < 0 withholds done entirely.
   task automatic alu(int d, logic [RW-1:0] r, logic e);
      int found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (alu_start) begin found = 1; break; end
      end
      chk("alu_start_seen", 32'(found), 32'd1);
      if (d >= 0 && found == 1) begin
         tick(d);
         alu_done = 1'b1; alu_result = r; alu_err = e;
         tick(1);
         alu_done = 1'b0; alu_err = 1'b0;
      end
   endtask

   task automatic go_b();
      key_b_n = 1'b0;
      tick(1);
      key_b_n = 1'b1;
   endtask

   int s0;
   int nb;

   initial begin
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_result", {5'b0, result}, 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);

      // 12 + 30; B pressed together with A must be dropped.
      sw_a = 18'd12; sw_b = 18'd77;
      key_a_n = 1'b0; key_b_n = 1'b0;
      tick(2);
      key_a_n = 1'b1; key_b_n = 1'b1;
      tick(3);
      chk("t1_state_op", 32'(state_o), 32'd1);
      chk("t1_op_a", 32'(op_a), 32'd12);
      sw_op = 2'(OP_ADD);
      press(1, 1);
      sw_b = 18'd30;
      s0 = n_start;
      go_b();
      alu(5, 27'd42, 1'b0);
      chk("t1_result", {5'b0, result}, 32'd42);
      chk("t1_valid", 32'(result_valid), 32'd1);
      chk("t1_state", 32'(state_o), 32'd4);
      chk("t1_starts", 32'(n_start - s0), 32'd1);

      // Held key: one transition, landing on edge 3.
      press(0, 1);
      sw_a = 18'd100;
      key_a_n = 1'b0;
      tick(2);
      chk("t2_before_e3", 32'(state_o), 32'd0);
      tick(1);
      chk("t2_at_e3", 32'(state_o), 32'd1);
      tick(17);
      key_a_n = 1'b1;
      tick(4);
      chk("t2_held", 32'(state_o), 32'd1);
      chk("t2_op_a", 32'(op_a), 32'd100);

      // Timeout after TO exec cycles.
      sw_op = 2'(OP_SUB);
      press(1, 1);
      sw_b = 18'd5;
      go_b();
      alu(-1, '0, 1'b0);
      nb = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) nb++;
         else break;
      end
      chk("t3_exec_cycles", 32'(nb), 32'(TO));
      chk("t3_code", 32'(err_code), 32'd2);
      chk("t3_state", 32'(state_o), 32'd5);
      tick(1);
      press(0, 1);
      chk("t3_clear", 32'(err), 32'd0);

      // Done in the final exec cycle wins.
      sw_a = 18'd1000;
      press(0, 1);
      press(1, 1);
      sw_b = 18'd234;
      go_b();
      alu(TO - 1, 27'd1234, 1'b0);
      chk("t3_late_state", 32'(state_o), 32'd4);
      chk("t3_late_res", {5'b0, result}, 32'd1234);

      // Divide by zero.
      press(0, 1);
      sw_a = 18'd7;
      press(0, 1);
      sw_op = 2'(OP_DIV);
      press(1, 1);
      sw_b = 18'd0;
      go_b();
      alu(3, 27'd999, 1'b1);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_code", 32'(err_code), 32'd1);
      chk("t4_keep", {5'b0, result}, 32'd1234);
      press(0, 1);
      chk("t4_state", 32'(state_o), 32'd0);
      chk("t4_err_clr", 32'(err), 32'd0);

      // Chain mode.
      sw_a = 18'd12;
      press(0, 1);
      sw_op = 2'(OP_ADD);
      press(1, 1);
      sw_b = 18'd30;
      go_b();
      alu(2, 27'd42, 1'b0);
      chk("t5_res", {5'b0, result}, 32'd42);
      chain_en = 1'b0;
      press(1, 1);
      chk("t5_no_chain", 32'(state_o), 32'd4);
      chain_en = 1'b1;
      press(1, 1);
      chk("t5_chain_st", 32'(state_o), 32'd1);
      chk("t5_chain_a", 32'(op_a), 32'd42);
      press(1, 1);
      go_b();
      alu(4, 27'h100000, 1'b0);
      chk("t5_big", {5'b0, result}, 32'h100000);
      press(1, 1);
      chk("t5_ovf_st", 32'(state_o), 32'd5);
      chk("t5_ovf_code", 32'(err_code), 32'd3);
      chain_en = 1'b0;

      // Soft clear, then reset during exec.
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      chk("t6_clr_st", 32'(state_o), 32'd0);
      chk("t6_clr_err", 32'(err), 32'd0);
      chk("t6_clr_res", {5'b0, result}, 32'h100000);
      sw_a = 18'd3;
      press(0, 1);
      sw_a = 18'd0;
      press(1, 1);
      go_b();
      alu(-1, '0, 1'b0);
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      alu_done = 1'b1; alu_result = 27'd555;
      tick(1);
      alu_done = 1'b0;
      tick(1);
      chk("t6_rst_st", 32'(state_o), 32'd0);
      chk("t6_rst_res", {5'b0, result}, 32'd0);
      chk("t6_rst_opb", 32'(op_b), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_valid", 32'(result_valid), 32'd0);
      chk("t6_rst_code", 32'(err_code), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
